video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Upstream source stage for hdmi_tx. Generates the CEA 640x480@60 raster timing on the 25 MHz pixclk domain.
- Drives the red, green, blue, hsync, vsync, vde and cntrl inputs of hdmi_tx with a selectable test pattern.
- Replaces the hdmi_rx loopback as the video source for standalone bring-up.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- pixclk  in  1  pixel clock, 25 MHz, only clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = run raster; 0 = hold counters at 0, outputs idle
- pattern_sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 moving bar
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- vde  out  1  video data enable
- cntrl  out  4  TMDS control bits, constant 4'b0000
- hcount  out  12  horizontal position of the current output pixel
- vcount  out  12  vertical position of the current output pixel
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters = 800; V_TOTAL = sum of the four V parameters = 525.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on the h wrap and wraps to 0 after V_TOTAL-1.
- Decode (registered):
  - vde = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), changing at h_cnt = 0
- Latency: exactly 1 pixclk from the counter value to every output. rgb, syncs, vde, hcount, vcount and frame_start are mutually aligned.
- rgb is forced to 0 whenever vde = 0.
- Reset (rst low, asynchronous) and enable low (synchronous, next edge):
  - counters = 0, rgb = 0, vde = 0, frame_start = 0
  - hsync and vsync = ~SYNC_POL
  - active pattern = 0, bar position = 0
- On enable rising, the raster starts at (0,0) and frame_start pulses with the first output pixel.
- pattern_sel is sampled only when h_cnt = 0 and v_cnt = 0. A mid-frame change takes effect at the next frame and never tears.
- Pattern 0, colour bars:
  - 8 bars of H_ACTIVE/8 = 80 px each, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Bar index comes from a within-bar counter plus a 3-bit bar counter, reset at h_cnt = 0. No divider.
- Pattern 1, grey ramp: r = g = b = h_cnt[9:2].
- Pattern 2, checkerboard: h_cnt[5] ^ v_cnt[5] ? FFFFFF : 000000.
- Pattern 3, moving bar:
  - White 16-px vertical bar at x in [bar_pos, bar_pos+16); all other pixels black.
  - bar_pos += 4 at each frame start. If the result is >= H_ACTIVE it wraps to 0.
  - Pixels past H_ACTIVE-1 are not drawn; no wrap-around of the bar itself.
- frame_start and output pixel (0,0) occur in the same cycle. Frame period is H_TOTAL*V_TOTAL = 420000 cycles.

Decomposition:
- Package hdmi_video_pkg:
  - default 640x480 timing constants
  - 2-bit pattern enum (PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_MOVE)
  - 24-bit colour constants for the 8 bars
- Sub-module video_pattern_gen:
  - inputs h_cnt, v_cnt, active pattern, bar_pos
  - registered rgb output
  - the top keeps the counters, sync decode and the pattern/bar_pos registers

Test Plan:
- Reset released, enable = 1:
  - first post-reset output has vde = 1, hcount = 0, vcount = 0, frame_start = 1
  - hsync low for output hcount 656..751 only
  - line period 800 cycles
- Full frame:
  - vsync low for vcount 490..491
  - vde = 0 for vcount 480..524 and for hcount 640..799
  - frame_start spacing 420000 cycles
  - rgb = 0 whenever vde = 0
- pattern_sel = 0, line 0:
  - hcount 0 and 79 -> FFFFFF
  - hcount 80 -> FFFF00
  - hcount 400 -> FF0000
  - hcount 639 -> 000000
- pattern_sel switched 0 -> 2 at vcount 100:
  - remainder of the frame stays colour bars
  - next frame: (0,0) -> 000000, (32,0) -> FFFFFF, (32,32) -> 000000
- pattern_sel = 3 over 161 frames:
  - bar starts at x = 0, 4, 8, ... on successive frames
  - after bar_pos = 636 it returns to 0
  - at bar_pos = 636 only pixels 636..639 are white
- enable deasserted mid-line, then async rst asserted mid-frame:
  - enable low: next edge gives vde = 0, hsync = vsync = 1, counters 0
  - rst low: outputs reach reset values with no pixclk edge
  - re-enable: raster restarts with frame_start

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// rtl/hdmi_video_pkg.sv - shared timing defaults, pattern enum and colour constants
// Used by the raster generator and its pattern stage.
package hdmi_video_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int MOVE_BAR_W = 16;
  localparam int MOVE_STEP  = 4;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_MOVE  = 2'd3
  } pattern_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - test pattern pixel generator with registered rgb
// Takes the live counters and returns the pixel colour one clock later.
module video_pattern_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             active,
  input  logic [CNT_W-1:0] h_cnt,
  input  logic [CNT_W-1:0] v_cnt,
  input  pattern_e         pattern,
  input  logic [CNT_W-1:0] bar_pos,
  output logic [23:0]      rgb
);

  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [CNT_W-1:0] MOVE_W   = CNT_W'(MOVE_BAR_W);

  logic [CNT_W-1:0] px_q, px_cur;
  logic [2:0]       idx_q, idx_cur;
  logic [23:0]      pix;
  logic             unused_v;

  assign unused_v = ^{v_cnt[CNT_W-1:6], v_cnt[4:0]};

  // Colour-bar index tracks the pixel position with a pair of counters instead of a divide.
  always_comb begin
    px_cur  = (h_cnt == '0) ? '0 : px_q;
    idx_cur = (h_cnt == '0) ? 3'd0 : idx_q;
    pix     = COL_BLACK;
    case (pattern)
      PAT_BARS:  pix = bar_colour(idx_cur);
      PAT_RAMP:  pix = {3{h_cnt[9:2]}};
      PAT_CHECK: pix = (h_cnt[5] ^ v_cnt[5]) ? COL_WHITE : COL_BLACK;
      PAT_MOVE:  pix = (h_cnt >= bar_pos && h_cnt < bar_pos + MOVE_W) ? COL_WHITE : COL_BLACK;
      default:   pix = COL_BLACK;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      px_q  <= '0;
      idx_q <= 3'd0;
      rgb   <= '0;
    end else if (!enable) begin
      px_q  <= '0;
      idx_q <= 3'd0;
      rgb   <= '0;
    end else begin
      if (px_cur == BAR_LAST) begin
        px_q  <= '0;
        idx_q <= idx_cur + 3'd1;
      end else begin
        px_q  <= px_cur + 1'b1;
        idx_q <= idx_cur;
      end
      rgb <= active ? pix : '0;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing and test-pattern source for hdmi_tx
// Counters, sync decode and frame-level pattern/bar registers; pixels come from video_pattern_gen.
module video_timing_gen
  import hdmi_video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             hsync,
  output logic             vsync,
  output logic             vde,
  output logic [3:0]       cntrl,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(MOVE_STEP);

  logic [CNT_W-1:0] h_cnt, v_cnt, bar_pos, bar_next;
  logic             frame_origin, frame_last, active;
  pattern_e         pat_q, pat_eff;
  logic [23:0]      rgb;

  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign bar_next     = (bar_pos + STEP >= H_ACT) ? '0 : bar_pos + STEP;
  assign cntrl        = 4'b0000;
  assign {red, green, blue} = rgb;

  // The freshly sampled selection must already drive pixel (0,0) so a frame never mixes patterns.
  assign pat_eff = frame_origin ? pattern_e'(pattern_sel) : pat_q;

  always_ff @(posedge pixclk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hcount      <= '0;
      vcount      <= '0;
      vde         <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      pat_q       <= PAT_BARS;
      bar_pos     <= '0;
    end else if (!enable) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hcount      <= '0;
      vcount      <= '0;
      vde         <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      pat_q       <= PAT_BARS;
      bar_pos     <= '0;
    end else begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
      if (h_cnt == H_LAST) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      vde         <= active;
      hsync       <= (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_start <= frame_origin;
      if (frame_origin) begin
        pat_q <= pattern_e'(pattern_sel);
      end
      // Advancing on the last pixel keeps bar_pos stable for the whole of the next frame.
      if (frame_last) begin
        bar_pos <= bar_next;
      end
    end
  end

  video_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pattern (
    .pixclk  (pixclk),
    .rst     (rst),
    .enable  (enable),
    .active  (active),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .pattern (pat_eff),
    .bar_pos (bar_pos),
    .rgb     (rgb)
  );

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen
// Full-size instance for line timing; reduced-raster instance for frame-level behaviour.
module tb_video_timing_gen;

  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  logic       rst;
  logic       d_en, s_en;
  logic [1:0] d_sel, s_sel;

  logic [7:0]  d_red, d_green, d_blue, s_red, s_green, s_blue;
  logic        d_hs, d_vs, d_vde, d_fs, s_hs, s_vs, s_vde, s_fs;
  logic [3:0]  d_cntrl, s_cntrl;
  logic [11:0] d_hc, d_vc, s_hc, s_vc;

  int n_cmp = 0;
  int n_err = 0;

  video_timing_gen dut (
    .pixclk(pixclk), .rst(rst), .enable(d_en), .pattern_sel(d_sel),
    .red(d_red), .green(d_green), .blue(d_blue),
    .hsync(d_hs), .vsync(d_vs), .vde(d_vde), .cntrl(d_cntrl),
    .hcount(d_hc), .vcount(d_vc), .frame_start(d_fs)
  );

  // Small raster: 80 x 38 total, 64 x 34 active, 3040 cycles per frame.
  video_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (
    .pixclk(pixclk), .rst(rst), .enable(s_en), .pattern_sel(s_sel),
    .red(s_red), .green(s_green), .blue(s_blue),
    .hsync(s_hs), .vsync(s_vs), .vde(s_vde), .cntrl(s_cntrl),
    .hcount(s_hc), .vcount(s_vc), .frame_start(s_fs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rgb_model(input int pat, input int hc, input int vc,
                                            input int bar, input int bar_w);
    logic [11:0] h, v;
    logic [23:0] c;
    h = 12'(hc);
    v = 12'(vc);
    case (pat)
      0: case (hc / bar_w)
           0: c = 24'hFFFFFF;
           1: c = 24'hFFFF00;
           2: c = 24'h00FFFF;
           3: c = 24'h00FF00;
           4: c = 24'hFF00FF;
           5: c = 24'hFF0000;
           6: c = 24'h0000FF;
           default: c = 24'h000000;
         endcase
      1: c = {3{h[9:2]}};
      2: c = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
      default: c = (hc >= bar && hc < bar + 16) ? 24'hFFFFFF : 24'h000000;
    endcase
    return c;
  endfunction

  task automatic check_d(input int k);
    int hc, vc;
    logic vde_e;
    hc = k % 800;
    vc = k / 800;
    vde_e = (hc < 640) && (vc < 480);
    check_val("d_hcount", 32'(d_hc), 32'(hc));
    check_val("d_vcount", 32'(d_vc), 32'(vc));
    check_val("d_vde", 32'(d_vde), 32'(vde_e));
    check_val("d_hsync", 32'(d_hs), (hc >= 656 && hc < 752) ? 32'd0 : 32'd1);
    check_val("d_vsync", 32'(d_vs), 32'd1);
    check_val("d_frame_start", 32'(d_fs), (k == 0) ? 32'd1 : 32'd0);
    check_val("d_rgb", 32'({d_red, d_green, d_blue}), vde_e ? 32'(rgb_model(0, hc, vc, 0, 80)) : 32'd0);
  endtask

  task automatic check_s(input int k, input int pat);
    int hc, vc, bar;
    logic vde_e;
    hc  = k % 80;
    vc  = (k / 80) % 38;
    bar = (4 * (k / 3040)) % 64;
    vde_e = (hc < 64) && (vc < 34);
    check_val("s_hcount", 32'(s_hc), 32'(hc));
    check_val("s_vcount", 32'(s_vc), 32'(vc));
    check_val("s_vde", 32'(s_vde), 32'(vde_e));
    check_val("s_hsync", 32'(s_hs), (hc >= 68 && hc < 76) ? 32'd0 : 32'd1);
    check_val("s_vsync", 32'(s_vs), (vc >= 35 && vc < 37) ? 32'd0 : 32'd1);
    check_val("s_frame_start", 32'(s_fs), (hc == 0 && vc == 0) ? 32'd1 : 32'd0);
    check_val("s_rgb", 32'({s_red, s_green, s_blue}), vde_e ? 32'(rgb_model(pat, hc, vc, bar, 8)) : 32'd0);
  endtask

  initial begin
    rst = 1'b0; d_en = 1'b1; s_en = 1'b0; d_sel = 2'd0; s_sel = 2'd0;
    repeat (3) @(negedge pixclk);
    check_val("rst_vde", 32'(d_vde), 32'd0);
    check_val("rst_hsync", 32'(d_hs), 32'd1);
    check_val("rst_vsync", 32'(d_vs), 32'd1);
    check_val("rst_hcount", 32'(d_hc), 32'd0);
    check_val("rst_frame_start", 32'(d_fs), 32'd0);
    check_val("rst_rgb", 32'({d_red, d_green, d_blue}), 32'd0);
    check_val("rst_cntrl", 32'(d_cntrl), 32'd0);

    // Full-size raster: lines 0 and 1 with colour bars
    rst = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      @(negedge pixclk);
      check_d(k);
    end

    // Enable dropped mid-line while hsync is asserted
    repeat (701) @(negedge pixclk);
    check_val("mid_hsync_low", 32'(d_hs), 32'd0);
    d_en = 1'b0;
    @(negedge pixclk);
    check_val("dis_vde", 32'(d_vde), 32'd0);
    check_val("dis_hsync", 32'(d_hs), 32'd1);
    check_val("dis_vsync", 32'(d_vs), 32'd1);
    check_val("dis_hcount", 32'(d_hc), 32'd0);
    check_val("dis_vcount", 32'(d_vc), 32'd0);
    check_val("dis_rgb", 32'({d_red, d_green, d_blue}), 32'd0);
    repeat (3) @(negedge pixclk);
    check_val("dis_hold_fs", 32'(d_fs), 32'd0);
    d_en = 1'b1;
    @(negedge pixclk);
    check_val("reen_frame_start", 32'(d_fs), 32'd1);
    check_val("reen_hcount", 32'(d_hc), 32'd0);
    check_val("reen_rgb", 32'({d_red, d_green, d_blue}), 32'hFFFFFF);
    repeat (9) @(negedge pixclk);
    check_val("pre_rst_vde", 32'(d_vde), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b0;
    #1;
    check_val("arst_vde", 32'(d_vde), 32'd0);
    check_val("arst_rgb", 32'({d_red, d_green, d_blue}), 32'd0);
    check_val("arst_hcount", 32'(d_hc), 32'd0);
    check_val("arst_hsync", 32'(d_hs), 32'd1);
    @(negedge pixclk);
    rst = 1'b1;
    @(negedge pixclk);
    check_val("rerst_frame_start", 32'(d_fs), 32'd1);
    check_val("rerst_hcount", 32'(d_hc), 32'd0);
    check_val("rerst_vde", 32'(d_vde), 32'd1);

    // Small raster: bars -> checker -> ramp, switched mid-frame each time
    s_en = 1'b1;
    s_sel = 2'd0;
    for (int k = 0; k < 3 * 3040; k++) begin
      @(negedge pixclk);
      check_s(k, (k < 3040) ? 0 : (k < 6080) ? 2 : 1);
      if (k == 800)        s_sel = 2'd2;
      if (k == 3040 + 800) s_sel = 2'd1;
      if (k == 6080 + 800) s_sel = 2'd3;
    end

    // Moving bar from a fresh start, through the wrap back to 0
    s_en = 1'b0;
    @(negedge pixclk);
    check_val("s_dis_hcount", 32'(s_hc), 32'd0);
    check_val("s_dis_vde", 32'(s_vde), 32'd0);
    s_en = 1'b1;
    for (int k = 0; k < 17 * 3040; k++) begin
      @(negedge pixclk);
      check_s(k, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
